multicycle_ctrl: RTL and testbench

- Multi-cycle control unit that drives the RV32I datapath's control inputs.
- Consumes the datapath's decoded fields (`opcode`, `funct7`, `funct3`).
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Produces `reg_write`, `mem2reg`, `alu_src`, `mem_write`, `mem_read` and `alu_cc`, plus PC/IR enables for a multi-cycle datapath variant.
- Supports R-type ALU, I-type ALU, `lw` and `sw`; flags anything else as illegal and halts.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/alu_decoder.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and legality check
// for the multi-cycle RV32I control unit.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int CNT_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  function automatic logic is_legal(
    input logic [6:0] op,
    input logic [6:0] f7,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R:     ok = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000);
      OP_I:     ok = 1'b1;
      OP_LOAD:  ok = (f3 == 3'b010);
      OP_STORE: ok = (f3 == 3'b010);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps latched opcode/funct fields to the ALU control code.
// Memory ops and unknown opcodes fall back to ADD.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_CC_W = 4
) (
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  output logic [ALU_CC_W-1:0] alu_cc
);

  logic       is_r;
  logic       is_i;
  logic       alt;
  logic [3:0] code;
  logic       unused_f7;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign alt       = funct7[5];
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    code = ALU_ADD;
    unique case (1'b1)
      is_r, is_i: begin
        unique case (funct3)
          3'b000: code = (is_r && alt) ? ALU_SUB
                                       : ALU_ADD;
          3'b001: code = ALU_SLL;
          3'b010: code = ALU_SLT;
          3'b011: code = ALU_SLT;
          3'b100: code = ALU_XOR;
          3'b101: code = alt ? ALU_SRA : ALU_SRL;
          3'b110: code = ALU_OR;
          3'b111: code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_cc = ALU_CC_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb
// sequencing for R/I-type ALU ops, lw and sw.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CC_W = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  output logic                ir_en,
  output logic                pc_en,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                instr_done,
  output logic                illegal
);

  state_t             state;
  state_t             nxt;
  logic [6:0]         op_q;
  logic [6:0]         f7_q;
  logic [2:0]         f3_q;
  logic [CNT_W-1:0]   cnt;
  logic [ALU_CC_W-1:0] dec_cc;
  logic               is_ld;
  logic               is_st;
  logic               mem_last;

  assign is_ld    = (op_q == OP_LOAD);
  assign is_st    = (op_q == OP_STORE);
  assign mem_last = (cnt == '0);

  alu_decoder #(
    .ALU_CC_W(ALU_CC_W)
  ) u_alu_dec (
    .opcode(op_q),
    .funct7(f7_q),
    .funct3(f3_q),
    .alu_cc(dec_cc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      f7_q <= '0;
      f3_q <= '0;
      cnt  <= '0;
    end else begin
      if (state == S_DECODE) begin
        op_q <= opcode;
        f7_q <= funct7;
        f3_q <= funct3;
      end
      if (state == S_EXEC)
        cnt <= CNT_W'(MEM_WAIT);
      else if (state == S_MEM && !mem_last)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = is_legal(opcode, funct7, funct3)
                      ? S_EXEC : S_TRAP;
      S_EXEC:   nxt = (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:    if (mem_last) nxt = is_ld ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is held, even mid-instruction.
  always_comb begin
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    mem2reg    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_cc     = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: ir_en = 1'b1;
        S_DECODE: ;
        S_EXEC: begin
          alu_src = (op_q != OP_R);
          alu_cc  = dec_cc;
        end
        S_MEM: begin
          alu_src   = 1'b1;
          alu_cc    = dec_cc;
          mem_read  = is_ld;
          mem_write = is_st;
          if (is_st && mem_last) begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          alu_src    = (op_q != OP_R);
          alu_cc     = dec_cc;
          reg_write  = 1'b1;
          mem2reg    = is_ld;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for multicycle_ctrl,
// two instances with MEM_WAIT=2 and MEM_WAIT=0.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [6:0] funct7 = '0;
  logic [2:0] funct3 = '0;

  logic       a_ir, a_pc, a_rw, a_m2r, a_src;
  logic       a_rd, a_wr, a_done, a_ill;
  logic [3:0] a_cc;
  logic       b_ir, b_pc, b_rw, b_m2r, b_src;
  logic       b_rd, b_wr, b_done, b_ill;
  logic [3:0] b_cc;

  int total = 0;
  int passed = 0;

  logic [12:0] ev[$];
  logic [12:0] fe, de, tr;

  multicycle_ctrl #(.ALU_CC_W(4), .MEM_WAIT(2)) u_dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .ir_en(a_ir), .pc_en(a_pc), .reg_write(a_rw),
    .mem2reg(a_m2r), .alu_src(a_src),
    .mem_read(a_rd), .mem_write(a_wr),
    .alu_cc(a_cc), .instr_done(a_done), .illegal(a_ill)
  );

  multicycle_ctrl #(.ALU_CC_W(4), .MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .ir_en(b_ir), .pc_en(b_pc), .reg_write(b_rw),
    .mem2reg(b_m2r), .alu_src(b_src),
    .mem_read(b_rd), .mem_write(b_wr),
    .alu_cc(b_cc), .instr_done(b_done), .illegal(b_ill)
  );

  always #5 clk = ~clk;

  wire [12:0] va = {a_ir, a_pc, a_rw, a_m2r, a_src,
                    a_rd, a_wr, a_done, a_ill, a_cc};
  wire [12:0] vb = {b_ir, b_pc, b_rw, b_m2r, b_src,
                    b_rd, b_wr, b_done, b_ill, b_cc};

  // ir pc rw m2r src rd wr done ill cc
  function automatic logic [12:0] v(
    input logic ir, pc, rw, m2r, src,
    input logic rd, wr, done, ill,
    input logic [3:0] cc
  );
    return {ir, pc, rw, m2r, src, rd, wr, done, ill, cc};
  endfunction

  task automatic check(
    input string tag,
    input logic [12:0] got,
    input logic [12:0] exp
  );
    total++;
    if (got !== exp)
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    else
      passed++;
  endtask

  // sel: 0 = MEM_WAIT=2 dut, 1 = MEM_WAIT=0 dut, 2 = both
  task automatic run(
    input string tag,
    input logic [6:0] op,
    input logic [6:0] f7,
    input logic [2:0] f3,
    input int sel
  );
    opcode = op;
    funct7 = f7;
    funct3 = f3;
    for (int i = 0; i < ev.size(); i++) begin
      @(negedge clk);
      if (sel != 1)
        check($sformatf("%s.a.c%0d", tag, i + 1), va, ev[i]);
      if (sel != 0)
        check($sformatf("%s.b.c%0d", tag, i + 1), vb, ev[i]);
      if (i == 2) begin
        opcode = 7'($urandom);
        funct7 = 7'($urandom);
        funct3 = 3'($urandom);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".a"}, va, 13'd0);
    check({tag, ".b"}, vb, 13'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    fe = v(1,0,0,0,0, 0,0,0,0, 4'b0000);
    de = 13'd0;
    tr = v(0,0,0,0,0, 0,0,0,1, 4'b0000);

    @(negedge clk);
    check("rst.a", va, 13'd0);
    check("rst.b", vb, 13'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    ev = '{fe, de,
           v(0,0,0,0,0, 0,0,0,0, 4'b0010),
           v(0,1,1,0,0, 0,0,1,0, 4'b0010)};
    run("add", 7'b0110011, 7'b0000000, 3'b000, 2);
    ev = '{fe, de,
           v(0,0,0,0,0, 0,0,0,0, 4'b0110),
           v(0,1,1,0,0, 0,0,1,0, 4'b0110)};
    run("sub", 7'b0110011, 7'b0100000, 3'b000, 2);
    ev = '{fe, de,
           v(0,0,0,0,0, 0,0,0,0, 4'b0001),
           v(0,1,1,0,0, 0,0,1,0, 4'b0001)};
    run("or", 7'b0110011, 7'b0000000, 3'b110, 2);
    ev = '{fe, de,
           v(0,0,0,0,1, 0,0,0,0, 4'b1010),
           v(0,1,1,0,1, 0,0,1,0, 4'b1010)};
    run("srai", 7'b0010011, 7'b0100000, 3'b101, 2);
    ev = '{fe, de,
           v(0,0,0,0,1, 0,0,0,0, 4'b0010),
           v(0,1,1,0,1, 0,0,1,0, 4'b0010)};
    run("addi", 7'b0010011, 7'b0100000, 3'b000, 2);

    do_reset("rst_lw");
    ev = '{fe, de,
           v(0,0,0,0,1, 0,0,0,0, 4'b0010),
           v(0,0,0,0,1, 1,0,0,0, 4'b0010),
           v(0,0,0,0,1, 1,0,0,0, 4'b0010),
           v(0,0,0,0,1, 1,0,0,0, 4'b0010),
           v(0,1,1,1,1, 0,0,1,0, 4'b0010)};
    run("lw", 7'b0000011, 7'b0000000, 3'b010, 0);

    do_reset("rst_sw");
    ev = '{fe, de,
           v(0,0,0,0,1, 0,0,0,0, 4'b0010),
           v(0,1,0,0,1, 0,1,1,0, 4'b0010)};
    run("sw", 7'b0100011, 7'b0000000, 3'b010, 1);

    do_reset("rst_ill");
    ev = '{fe, de};
    repeat (20) ev.push_back(tr);
    run("ill", 7'b1111111, 7'b0000000, 3'b000, 2);

    do_reset("clr_ill");
    ev = '{fe, de, tr, tr};
    run("lw_f3", 7'b0000011, 7'b0000000, 3'b000, 2);

    do_reset("clr_lwf3");
    ev = '{fe, de, tr};
    run("r_f7", 7'b0110011, 7'b0000001, 3'b000, 2);

    do_reset("clr_rf7");
    ev = '{fe, de,
           v(0,0,0,0,1, 0,0,0,0, 4'b0010),
           v(0,0,0,0,1, 1,0,0,0, 4'b0010)};
    run("lw_mid", 7'b0000011, 7'b0000000, 3'b010, 0);
    reset = 1'b1;
    #1;
    check("mid_rst", va, 13'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    ev = '{fe, de,
           v(0,0,0,0,0, 0,0,0,0, 4'b0011),
           v(0,1,1,0,0, 0,0,1,0, 4'b0011)};
    run("xor_after", 7'b0110011, 7'b0000000, 3'b100, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
